square: RTL and testbench

SQUARE -- requirements
Module: square

---
 rtl/square.sv | 88 ++++++++
 tb/tb_square.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/square.sv
// Iterative unsigned squarer: y = x*x by shift-and-add,
// one operand bit per clock, WIDTH cycles per operation.
module square #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   x_bi,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] y_bo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    WORK
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] y_q;
  logic               done_q;
  logic               last;

  // mcand holds operand << i, mplier[0] holds operand bit i
  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last    = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = WORK;
      WORK: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, x_bi};
            mplier_q <= x_bi;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        WORK: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            y_q    <= acc_nxt;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q == WORK);
  assign done_o = done_q;
  assign y_bo   = y_q;

endmodule

// File: tb/tb_square.sv
// Self-checking bench for square: directed corner cases plus
// exhaustive and random operands against arithmetic x*x.
module tb_square;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [W-1:0]   x_bi;
  logic           start_i;
  logic           busy_o;
  logic           done_o;
  logic [2*W-1:0] y_bo;

  int vectors = 0;
  int miscompares = 0;

  square #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .x_bi    (x_bi),
    .start_i (start_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .y_bo    (y_bo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One operation; optionally change x_bi on busy cycle chg_at
  task automatic run_op(input logic [W-1:0] x,
                        input int chg_at,
                        input logic [W-1:0] chg_x);
    int lat;
    int nbusy;
    int unsigned exp;
    exp = int'(x) * int'(x);
    x_bi = x;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    lat = 0;
    nbusy = 0;
    while (!done_o && lat < 4 * W) begin
      if (busy_o) nbusy++;
      if (lat == chg_at) x_bi = chg_x;
      step();
      lat++;
    end
    chk("latency", lat, W);
    chk("busy_cycles", nbusy, W);
    chk("result", y_bo, exp);
    chk("busy_at_done", busy_o, 0);
    step();
    chk("done_one_cycle", done_o, 0);
    chk("result_hold", y_bo, exp);
  endtask

  initial begin
    rst_i = 1'b1;
    x_bi = '0;
    start_i = 1'b0;
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_y", y_bo, 0);

    // start requests during reset are ignored
    @(negedge clk);
    start_i = 1'b1;
    x_bi = 8'd5;
    step();
    step();
    chk("rst_ignore_start", busy_o, 0);
    start_i = 1'b0;
    rst_i = 1'b0;
    step();
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);

    for (int x = 0; x <= 10; x++) run_op(W'(x), -1, '0);

    run_op(8'd255, -1, '0);
    run_op(8'd128, -1, '0);
    run_op(8'd1, -1, '0);

    run_op(8'd12, 2, 8'd200);

    // continuous start: 8 busy, 1 idle, repeating
    x_bi = 8'd7;
    start_i = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 27; j++) begin
      @(negedge clk);
      chk("cont_busy", busy_o, (j % 9) < 8);
      chk("cont_done", done_o, (j % 9) == 8);
      if (j >= 8) chk("cont_y", y_bo, 49);
      if (j == 26) start_i = 1'b0;
    end
    step();
    chk("cont_stop", busy_o, 0);

    // reset in the middle of an operation
    x_bi = 8'd9;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) step();
    chk("mid_busy", busy_o, 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_y", y_bo, 0);
    chk("mid_rst_done", done_o, 0);
    repeat (2) begin
      step();
      chk("mid_rst_nodone", done_o, 0);
    end
    rst_i = 1'b0;
    step();
    run_op(8'd9, -1, '0);

    for (int x = 0; x < 256; x++) run_op(W'(x), -1, '0);

    repeat (20) begin
      logic [W-1:0] rx;
      rx = W'($urandom_range(0, 255));
      run_op(rx, int'($urandom_range(0, W - 1)),
             W'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
